// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int OS_RATE   = 16;
  localparam int OS_MID    = 7;
  localparam int OS_LAST   = 15;
  localparam int DATA_BITS = 8;

  // Expected parity bit for a data byte; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider: one-cycle tick every DIV sysclk cycles.
module baud_tick_gen #(
  parameter int DIV = 326
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("baud_tick_gen: DIV out of range 2..65535");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled from a tick enable, valid/ack output.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DIV        = 326,
  parameter int PARITY_ODD = 0
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int OS_W = $clog2(OS_RATE);
  localparam int BI_W = $clog2(DATA_BITS);

  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_os16: PARITY_ODD must be 0 or 1");
  end

  logic tick;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BI_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 deliver;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
`endif

  always_comb begin
    state_d      = state_q;
    os_d         = os_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    deliver      = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d       = pbad_q;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          os_d = '0;
          if (!rxs_q) state_d = START;
        end
        START: begin
          os_d = os_q + 1'b1;
          if (os_q == OS_W'(OS_MID)) begin
            os_d    = '0;
            bit_d   = '0;
            state_d = rxs_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            pbad_d  = 1'b0;
`endif
          end
        end
        DATA: begin
          os_d = os_q + 1'b1;
          if (os_q == OS_W'(OS_LAST)) begin
            shift_d[bit_q] = rxs_q;
            bit_d          = bit_q + 1'b1;
            if (bit_q == BI_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          os_d = os_q + 1'b1;
          if (os_q == OS_W'(OS_LAST)) begin
            pbad_d       = (rxs_q != parity_bit(shift_q, PARITY_ODD[0]));
            parity_err_d = pbad_d;
            state_d      = STOP;
          end
        end
`endif
        STOP: begin
          os_d = os_q + 1'b1;
          if (os_q == OS_W'(OS_LAST)) begin
            os_d        = '0;
            frame_err_d = !rxs_q;
            state_d     = rxs_q ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
            deliver     = rxs_q && !pbad_q;
`else
            deliver     = rxs_q;
`endif
          end
        end
        BREAK: begin
          os_d = '0;
          if (rxs_q) state_d = IDLE;
        end
        default: begin
          os_d    = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Delivery beats a same-cycle ack; overrun only when an unacked byte is lost.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = !rx_ack;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      os_q         <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) pbad_q <= 1'b0;
    else        pbad_q <= pbad_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized bench for uart_rx_os16 against a tick-arithmetic frame model.
module tb_uart_rx_os16;
  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
  localparam logic PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  // Ticks from start detection to each sample point.
  localparam int START_REL = 8;
  localparam int PAR_REL   = START_REL + 16 * 9;
  localparam int STOP_REL  = START_REL + 16 * (9 + PEN);

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rxd    = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, parity_err, busy;

  uart_rx_os16 #(.DIV(DIV), .PARITY_ODD(0)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame positions are absolute tick offsets from the tick that first saw the line low.
  int         ecnt, tcnt, t0, mode;  // mode: 0 idle, 1 in frame, 2 line held low after bad stop
  logic       h1, h2;                // rxd as seen 1 and 2 edges ago
  logic [7:0] m_shift, m_data;
  logic       m_valid, m_ovr, m_ferr, m_perr, m_pbad;

  logic tick_now, ev_start, ev_glitch, ev_bit, ev_par, ev_stop, ev_brk_exit, m_deliver, par_bad;
  int   rel, bi;

  assign tick_now    = (ecnt % DIV) == DIV - 1;
  assign rel         = tcnt - t0;
  assign bi          = (rel - START_REL) / 16 - 1;
  assign ev_start    = tick_now && mode == 0 && !h2;
  assign ev_glitch   = tick_now && mode == 1 && rel == START_REL && h2;
  assign ev_bit      = tick_now && mode == 1 && rel >= START_REL + 16 && rel <= START_REL + 128
                       && ((rel - START_REL) % 16 == 0);
  assign ev_par      = (PEN == 1) && tick_now && mode == 1 && rel == PAR_REL;
  assign ev_stop     = tick_now && mode == 1 && rel == STOP_REL;
  assign ev_brk_exit = tick_now && mode == 2 && h2;
  assign par_bad     = h2 != ((^m_shift) ^ PODD);
  assign m_deliver   = ev_stop && h2 && !m_pbad;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= 0; tcnt <= 0; t0 <= 0; mode <= 0;
      h1 <= 1'b1; h2 <= 1'b1;
      m_shift <= '0; m_data <= '0;
      m_valid <= 1'b0; m_ovr <= 1'b0; m_ferr <= 1'b0; m_perr <= 1'b0; m_pbad <= 1'b0;
    end else begin
      h1     <= rxd;
      h2     <= h1;
      ecnt   <= ecnt + 1;
      m_ferr <= 1'b0;
      m_perr <= 1'b0;
      if (tick_now) tcnt <= tcnt + 1;
      if (ev_start) begin mode <= 1; t0 <= tcnt; m_pbad <= 1'b0; end
      if (ev_glitch) mode <= 0;
      if (ev_bit) m_shift[bi] <= h2;
      if (ev_par) begin m_pbad <= par_bad; m_perr <= par_bad; end
      if (ev_stop) begin mode <= h2 ? 0 : 2; m_ferr <= !h2; end
      if (ev_brk_exit) mode <= 0;
      if (m_deliver) begin
        m_valid <= 1'b1;
        m_data  <= m_shift;
        if (m_valid) m_ovr <= !rx_ack;
      end else if (rx_ack && m_valid) begin
        m_valid <= 1'b0;
        m_ovr   <= 1'b0;
      end
    end
  end

  always @(negedge sysclk) begin
    chk("rx_data",    {24'd0, rx_data}, {24'd0, m_data});
    chk("rx_valid",   {31'd0, rx_valid},   {31'd0, m_valid});
    chk("overrun",    {31'd0, overrun},    {31'd0, m_ovr});
    chk("frame_err",  {31'd0, frame_err},  {31'd0, m_ferr});
    chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
    chk("busy",       {31'd0, busy},       {31'd0, mode != 0});
  end

  // ---------------- DUT event monitors ----------------
  int   cyc = 0, fe_cnt = 0, pe_cnt = 0, busy_cyc = 0, last_rise = -1;
  logic prev_valid = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (frame_err)  fe_cnt   <= fe_cnt + 1;
    if (parity_err) pe_cnt   <= pe_cnt + 1;
    if (busy)       busy_cyc <= busy_cyc + 1;
    if (rx_valid && !prev_valid) last_rise <= cyc;
    prev_valid <= rx_valid;
  end

  // ---------------- stimulus ----------------
  int ack_mode = 0;  // 0 none, 1 random, 2 exactly on the stop-sample edge

  task automatic cyc1();
    @(posedge sysclk);
    #2;
    case (ack_mode)
      1:       rx_ack = ($urandom % 16 == 0);
      2:       rx_ack = ev_stop;
      default: rx_ack = 1'b0;
    endcase
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc1();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbad,
                            input int maxc, output int startc);
    logic [11:0] bits;
    int nb, cnt;
    nb = 10 + PEN;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PEN == 1) begin
      bits[9]  = (^b) ^ PODD ^ pbad;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    startc = cyc;
    cnt = 0;
    for (int k = 0; k < nb; k++) begin
      rxd = bits[k];
      for (int c = 0; c < BIT; c++) begin
        if (cnt >= maxc) return;
        cyc1();
        cnt++;
      end
    end
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    cyc1();
  endtask

  int sc, fb, pb, bb, lat;

  initial begin
    wait_n(3);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data",  {24'd0, rx_data},  32'd0);
    chk("reset_busy",  {31'd0, busy},     32'd0);
    rst_n = 1'b1;
    wait_n(20);

    // Clean byte: value, latency and no framing error.
    fb = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1;
    wait_n(10);
    lat = last_rise - sc;
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_data",  {24'd0, rx_data},  32'hA5);
    chk("a5_no_ferr", fe_cnt - fb, 32'd0);
    chk("a5_latency_window", {31'd0, (lat >= 611 + 64 * PEN) && (lat <= 614 + 64 * PEN)}, 32'd1);
    ack_once();
    chk("a5_ack_clears", {31'd0, rx_valid}, 32'd0);

    // Short low glitch while idle.
    bb = busy_cyc;
    rxd = 1'b0;
    wait_n(16);
    rxd = 1'b1;
    wait_n(200);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_busy_pulsed", {31'd0, busy_cyc > bb}, 32'd1);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);

    // Bad stop bit then line held low.
    fb = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 100000, sc);
    wait_n(3 * BIT);
    chk("break_busy", {31'd0, busy}, 32'd1);
    chk("break_ferr_once", fe_cnt - fb, 32'd1);
    chk("break_valid", {31'd0, rx_valid}, 32'd0);
    rxd = 1'b1;
    wait_n(50);
    chk("break_exit", {31'd0, busy}, 32'd0);

    // Overrun: two bytes without ack.
    send_frame(8'h11, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1; wait_n(10);
    send_frame(8'h22, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1; wait_n(10);
    chk("ovr_data",  {24'd0, rx_data}, 32'h22);
    chk("ovr_flag",  {31'd0, overrun}, 32'd1);
    ack_once();
    chk("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
    chk("ovr_ack_flag",  {31'd0, overrun},  32'd0);

    // Ack on the same cycle as the second delivery.
    send_frame(8'h5A, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1; wait_n(10);
    ack_mode = 2;
    send_frame(8'h99, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1;
    ack_mode = 0;
    wait_n(10);
    chk("sim_valid", {31'd0, rx_valid}, 32'd1);
    chk("sim_data",  {24'd0, rx_data},  32'h99);
    chk("sim_ovr",   {31'd0, overrun},  32'd0);
    ack_once();

`ifdef UART_RX_PARITY_EN
    pb = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 100000, sc);
    rxd = 1'b1; wait_n(10);
    chk("par_err_once", pe_cnt - pb, 32'd1);
    chk("par_no_deliver", {31'd0, rx_valid}, 32'd0);
`endif

    // Randomized frames with random acks, bad stops and bad parity.
    ack_mode = 1;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic st, pbd;
      b   = 8'($urandom);
      st  = ($urandom % 6) != 0;
      pbd = (PEN == 1) && (($urandom % 5) == 0);
      send_frame(b, st, pbd, 100000, sc);
      if (!st) wait_n($urandom_range(0, 2 * BIT));
      rxd = 1'b1;
      wait_n($urandom_range(1, 80));
    end
    ack_mode = 0;
    wait_n(20);
    if (rx_valid) ack_once();

    // Reset in the middle of the data bits with a byte pending.
    send_frame(8'hC3, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1; wait_n(10);
    send_frame(8'h5F, 1'b1, 1'b0, 4 * BIT, sc);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, rx_valid},  32'd0);
    chk("rst_data",  {24'd0, rx_data},   32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_ovr",   {31'd0, overrun},   32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    rxd = 1'b1;
    wait_n(5);
    rst_n = 1'b1;
    wait_n(30);
    chk("rst_no_partial", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h3A, 1'b1, 1'b0, 100000, sc);
    rxd = 1'b1; wait_n(10);
    chk("post_rst_data", {24'd0, rx_data}, 32'h3A);
    chk("post_rst_valid", {31'd0, rx_valid}, 32'd1);
    wait_n(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
